// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO control slice.
// Read-side FSM state and wrap-aware pointer distance.
package fifo_pkg;

  typedef enum logic {
    IDLE,
    VALID
  } fifo_rd_state_t;

  // Distance between two pw-bit wrapping pointers.
  function automatic int unsigned ptr_count(
    input int unsigned wr,
    input int unsigned rd,
    input int unsigned pw
  );
    return (wr - rd) & ((32'd1 << pw) - 32'd1);
  endfunction

endpackage

// File: rtl/fifo_flag_gen.sv
// FIFO status flags from occupancy and thresholds.
// In: occupancy, rd_valid, mem_full. Out: full/empty/almost_*.
module fifo_flag_gen #(
  parameter int SIZE = 4,
  parameter int AE   = 2,
  parameter int AF   = 14
) (
  input  logic [SIZE+1:0] i_occupancy,
  input  logic            i_rd_valid,
  input  logic            i_mem_full,
  output logic            o_full,
  output logic            o_empty,
  output logic            o_almost_full,
  output logic            o_almost_empty
);

  localparam int OW = SIZE + 2;

  assign o_full         = i_mem_full;
  assign o_empty        = !i_rd_valid;
  assign o_almost_empty = i_occupancy <= OW'(AE);
  assign o_almost_full  = i_occupancy >= OW'(AF);

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO control: pointers, RAM sequencing, read handshake.
// Ports: clk/reset_n/flush, wr_*, rd_*, mem_*, occupancy, flags.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int SIZE               = 4,
  parameter int ALMOST_EMPTY_VALUE = 2,
  parameter int ALMOST_FULL_VALUE  = 14
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            wr_valid,
  output logic            wr_ready,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic            mem_we,
  output logic [SIZE-1:0] mem_waddr,
  output logic            mem_re,
  output logic [SIZE-1:0] mem_raddr,
  output logic [SIZE+1:0] occupancy,
  output logic            full,
  output logic            empty,
  output logic            almost_full,
  output logic            almost_empty
);

  localparam int DEPTH = 2 ** SIZE;
  localparam int PW    = SIZE + 1;
  localparam int OW    = SIZE + 2;

  if (!(ALMOST_EMPTY_VALUE < ALMOST_FULL_VALUE &&
        ALMOST_FULL_VALUE <= DEPTH + 1)) begin : g_chk
    $error("fifo_ctrl: bad almost thresholds");
  end

  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  fifo_rd_state_t r_state;
  fifo_rd_state_t w_state_nxt;

  logic [PW-1:0] w_mem_count;
  logic          w_mem_full;
  logic          w_mem_empty;
  logic          w_push;
  logic          w_fetch;

  assign w_mem_count = PW'(ptr_count(32'(r_wr_ptr),
                                     32'(r_rd_ptr), PW));
  assign w_mem_full  = w_mem_count == PW'(DEPTH);
  assign w_mem_empty = w_mem_count == '0;

  assign wr_ready  = !w_mem_full && !flush;
  assign w_push    = wr_valid && wr_ready;
  assign mem_we    = w_push;
  assign mem_waddr = r_wr_ptr[SIZE-1:0];
  assign mem_raddr = r_rd_ptr[SIZE-1:0];
  assign mem_re    = w_fetch;
  assign rd_valid  = r_state == VALID;

  // Fetch decision uses the pre-push count, so a word
  // written to an empty RAM is never read the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_fetch     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_mem_empty) begin
          w_fetch     = 1'b1;
          w_state_nxt = VALID;
        end
      end
      VALID: begin
        if (rd_ready) begin
          if (!w_mem_empty) w_fetch = 1'b1;
          else w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (flush) begin
      w_fetch     = 1'b0;
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_state  <= IDLE;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_state  <= IDLE;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_push);
      r_rd_ptr <= r_rd_ptr + PW'(w_fetch);
      r_state  <= w_state_nxt;
    end
  end

  assign occupancy = OW'(w_mem_count) + OW'(rd_valid);

  fifo_flag_gen #(
    .SIZE (SIZE),
    .AE   (ALMOST_EMPTY_VALUE),
    .AF   (ALMOST_FULL_VALUE)
  ) u_flags (
    .i_occupancy    (occupancy),
    .i_rd_valid     (rd_valid),
    .i_mem_full     (w_mem_full),
    .o_full         (full),
    .o_empty        (empty),
    .o_almost_full  (almost_full),
    .o_almost_empty (almost_empty)
  );

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl with an external RAM model
// and a queue-based reference model of FIFO contents.
module tb_fifo_ctrl;

  localparam int SIZE  = 4;
  localparam int DEPTH = 16;
  localparam int AE    = 2;
  localparam int AF    = 14;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            flush;
  logic            wr_valid;
  logic            wr_ready;
  logic            rd_valid;
  logic            rd_ready;
  logic            mem_we;
  logic [SIZE-1:0] mem_waddr;
  logic            mem_re;
  logic [SIZE-1:0] mem_raddr;
  logic [SIZE+1:0] occupancy;
  logic            full;
  logic            empty;
  logic            almost_full;
  logic            almost_empty;

  always #5 clk = ~clk;

  fifo_ctrl #(
    .SIZE               (SIZE),
    .ALMOST_EMPTY_VALUE (AE),
    .ALMOST_FULL_VALUE  (AF)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_re       (mem_re),
    .mem_raddr    (mem_raddr),
    .occupancy    (occupancy),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  logic [31:0] ram [DEPTH];
  logic [31:0] dout;
  logic [31:0] wdata;

  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= wdata;
    if (mem_re) dout <= ram[mem_raddr];
  end

  int unsigned q[$];
  bit          ov;
  int unsigned ow;
  int unsigned tag;
  int          n_chk;
  int          n_pass;

  task automatic chk(input string t, input int got,
                     input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", t, got, exp);
  endtask

  task automatic clear_model();
    q.delete();
    ov = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_almost_empty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_re", mem_re, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    flush    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    clear_model();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One clock: drive, compare against the model, advance model.
  task automatic step(input bit wv, input bit rr, input bit fl);
    int occ;
    bit exp_wr, push, fetch, pop;
    @(negedge clk);
    wr_valid = wv;
    rd_ready = rr;
    flush    = fl;
    wdata    = tag;
    #1;
    occ    = q.size() + int'(ov);
    exp_wr = (q.size() < DEPTH) && !fl;
    push   = wv && exp_wr;
    fetch  = !fl && q.size() > 0 && (!ov || rr);
    pop    = ov && rr;
    chk("wr_ready", wr_ready, exp_wr);
    chk("mem_we", mem_we, push);
    chk("mem_re", mem_re, fetch);
    chk("rd_valid", rd_valid, ov);
    chk("occupancy", occupancy, occ);
    chk("full", full, q.size() == DEPTH);
    chk("empty", empty, !ov);
    chk("almost_empty", almost_empty, occ <= AE);
    chk("almost_full", almost_full, occ >= AF);
    if (pop) chk("rd_data", dout, ow);
    @(posedge clk);
    if (fl) begin
      clear_model();
    end else begin
      if (pop) ov = 1'b0;
      if (fetch) begin
        ow = q.pop_front();
        ov = 1'b1;
      end
      if (push) begin
        q.push_back(tag);
        tag++;
      end
    end
  endtask

  task automatic probe(input string t, input int exp);
    @(negedge clk);
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    flush    = 1'b0;
    #1;
    chk(t, occupancy, exp);
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    tag      = 32'h100;
    wdata    = '0;
    reset_n  = 1'b0;
    flush    = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    ov       = 1'b0;
    ow       = 0;

    do_reset();

    // single word: push, fetch, visible, pop
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("single_empty", empty, 1);

    // fill to full, then a stalled 18th write
    repeat (17) step(1, 0, 0);
    probe("fill_occ", 17);
    chk("fill_full", full, 1);
    chk("fill_wr_ready", wr_ready, 0);
    chk("fill_almost_full", almost_full, 1);
    step(1, 0, 0);

    // push and pop together while full
    repeat (6) step(1, 1, 0);
    repeat (20) step(0, 1, 0);

    // streaming from empty
    repeat (100) step(1, 1, 0);
    repeat (4) step(0, 1, 0);

    // wrap with interleaved push/pop pairs
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 0);
      step(0, 1, 0);
    end
    repeat (3) step(0, 1, 0);

    // flush with a pending write
    repeat (5) step(1, 0, 0);
    step(1, 0, 1);
    probe("flush_occ", 0);
    chk("flush_empty", empty, 1);
    step(0, 1, 0);

    // randomized traffic
    for (int i = 0; i < 2000; i++)
      step(1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 63) == 0));

    // reset mid-operation
    repeat (8) step(1, 0, 0);
    @(negedge clk);
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals();
    clear_model();
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 500; i++)
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
